// File: rtl/captura_pkg.sv
// Shared types for the OV7670 pixel capture block: output format codes,
// capture FSM states and the RGB565 down-conversion helper.
package captura_pkg;

    typedef enum logic [1:0] {
        MODE_RGB332 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_RGB565 = 2'd2
    } out_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // b0 = R4..R0 G5..G3, b1 = G2..G0 B4..B0; result is right-justified in 16 bits
    function automatic logic [15:0] rgb_convert(input out_mode_e mode,
                                                input logic [7:0] b0,
                                                input logic [7:0] b1);
        case (mode)
            MODE_RGB332: return {8'd0, b0[7:5], b0[2:0], b1[4:3]};
            MODE_RGB444: return {4'd0, b0[7:4], b0[2:0], b1[7], b1[4:1]};
            default:     return {b0, b1};
        endcase
    endfunction

endpackage

// File: rtl/captura_pixel_pack.sv
// Pairs camera bytes into RGB565 pixels and converts them to the output format.
// pix_valid is high in the cycle the second byte of a pixel is on data.
module pixel_pack
    import captura_pkg::*;
#(
    parameter int OUT_MODE = 0,
    parameter int OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             href,
    input  logic             hr_rise,
    input  logic [7:0]       data,
    output logic             pix_valid,
    output logic [OUT_W-1:0] pix_data
);

    localparam out_mode_e MODE = out_mode_e'(OUT_MODE[1:0]);

    logic       phase;
    logic [7:0] b0;
    logic       phase_eff;

    // The first byte after a line start is always phase 0, even if phase was left set.
    assign phase_eff = phase & ~hr_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            b0    <= 8'd0;
        end else if (!en || !href) begin
            // NOTE: a trailing odd byte simply dies here; phase restarts at 0 with the next line.
            phase <= 1'b0;
        end else begin
            phase <= ~phase_eff;
            if (!phase_eff) begin
                b0 <= data;
            end
        end
    end

    assign pix_valid = en & href & phase_eff;
    assign pix_data  = (OUT_W)'(rgb_convert(MODE, b0, data));

endmodule

// File: rtl/captura_pixel.sv
// OV7670 frame capture: arms on request, waits for a frame start, writes each
// converted pixel inside the H_RES x V_RES window to a linear frame-buffer address.
module captura_pixel
    import captura_pkg::*;
#(
    parameter int H_RES    = 160,
    parameter int V_RES    = 120,
    parameter int ADDR_W   = 17,
    parameter int OUT_MODE = 0,
    parameter int OUT_W    = 8
) (
    input  logic              Pclk,
    input  logic              Rst,
    input  logic              Arm,
    input  logic              Continuous,
    input  logic              Vsync,
    input  logic              Href,
    input  logic [7:0]        Data,
    output logic              regWrite,
    output logic [ADDR_W-1:0] addr_in,
    output logic [OUT_W-1:0]  data_in,
    output logic              Busy,
    output logic              Done,
    output logic              Frame_err
);

    if (!((OUT_MODE == 0 && OUT_W == 8) || (OUT_MODE == 1 && OUT_W == 12) ||
          (OUT_MODE == 2 && OUT_W == 16))) begin : g_bad_out_w
        $error("captura_pixel: OUT_W does not match OUT_MODE");
    end
    if ((longint'(1) << ADDR_W) < longint'(H_RES) * longint'(V_RES)) begin : g_bad_addr_w
        $error("captura_pixel: ADDR_W too small for H_RES*V_RES");
    end

    localparam logic [15:0] H_LIM = 16'(H_RES);
    localparam logic [15:0] V_LIM = 16'(V_RES);

    state_e             state, state_nx;
    logic               vs_q, hr_q;
    logic               vs_fall, vs_rise, hr_rise, hr_fall;
    logic [15:0]        x, y;
    logic [ADDR_W-1:0]  addr_cnt;
    logic               line_err;
    logic               capturing;
    logic               pix_valid;
    logic [OUT_W-1:0]   pix_data;
    logic               keep;
    logic               err_now;
    logic [15:0]        y_now;

    assign vs_fall   = vs_q & ~Vsync;
    assign vs_rise   = ~vs_q & Vsync;
    assign hr_rise   = ~hr_q & Href;
    assign hr_fall   = hr_q & ~Href;
    assign capturing = (state == CAPTURE);

    pixel_pack #(.OUT_MODE(OUT_MODE), .OUT_W(OUT_W)) u_pack (
        .clk       (Pclk),
        .rst       (Rst),
        .en        (capturing),
        .href      (Href),
        .hr_rise   (hr_rise),
        .data      (Data),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    assign keep    = pix_valid && (x < H_LIM) && (y < V_LIM);
    // Fold in a line that ends in the same cycle as the frame so it is not missed.
    assign err_now = line_err | (hr_fall && (x != H_LIM));
    assign y_now   = hr_fall ? y + 16'd1 : y;

    always_ff @(posedge Pclk) begin
        if (Rst) begin
            state     <= IDLE;
            vs_q      <= 1'b0;
            hr_q      <= 1'b0;
            x         <= 16'd0;
            y         <= 16'd0;
            addr_cnt  <= '0;
            line_err  <= 1'b0;
            regWrite  <= 1'b0;
            addr_in   <= '0;
            data_in   <= '0;
            Frame_err <= 1'b0;
        end else begin
            state    <= state_nx;
            vs_q     <= Vsync;
            hr_q     <= Href;
            regWrite <= keep;
            if (keep) begin
                addr_in  <= addr_cnt;
                data_in  <= pix_data;
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
            if (state == IDLE && Arm) begin
                Frame_err <= 1'b0;
            end
            if (state == WAIT_VS && vs_fall) begin
                x        <= 16'd0;
                y        <= 16'd0;
                addr_cnt <= '0;
                line_err <= 1'b0;
            end
            if (capturing) begin
                // Counters saturate so an over-long line or frame cannot wrap back into the window.
                if (pix_valid && x != 16'hFFFF) begin
                    x <= x + 16'd1;
                end
                if (hr_fall) begin
                    x <= 16'd0;
                    if (y != 16'hFFFF) begin
                        y <= y + 16'd1;
                    end
                    if (x != H_LIM) begin
                        line_err <= 1'b1;
                    end
                end
                if (vs_rise) begin
                    Frame_err <= err_now | (y_now != V_LIM);
                end
            end
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (Arm)     state_nx = WAIT_VS;
            WAIT_VS: if (vs_fall) state_nx = CAPTURE;
            CAPTURE: if (vs_rise) state_nx = DONE;
            DONE:    state_nx = Continuous ? WAIT_VS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_captura_pixel.sv
// Directed bench for captura_pixel: three builds (RGB332/444/565) share one
// camera stream; a conversion table drives the first frame, then corner-case sequences.
module tb_captura_pixel;

    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic Rst, Arm, Continuous, Vsync, Href;
    logic [7:0] Data;

    logic          rw0, rw1, rw2;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [7:0]    dat0;
    logic [11:0]   dat1;
    logic [15:0]   dat2;
    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;
    logic          err0, err1, err2;

    always #5 clk = ~clk;

    captura_pixel #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .OUT_MODE(0), .OUT_W(8)) dut0 (
        .Pclk(clk), .Rst(Rst), .Arm(Arm), .Continuous(Continuous), .Vsync(Vsync),
        .Href(Href), .Data(Data), .regWrite(rw0), .addr_in(addr0), .data_in(dat0),
        .Busy(busy0), .Done(done0), .Frame_err(err0));

    captura_pixel #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .OUT_MODE(1), .OUT_W(12)) dut1 (
        .Pclk(clk), .Rst(Rst), .Arm(Arm), .Continuous(Continuous), .Vsync(Vsync),
        .Href(Href), .Data(Data), .regWrite(rw1), .addr_in(addr1), .data_in(dat1),
        .Busy(busy1), .Done(done1), .Frame_err(err1));

    captura_pixel #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .OUT_MODE(2), .OUT_W(16)) dut2 (
        .Pclk(clk), .Rst(Rst), .Arm(Arm), .Continuous(Continuous), .Vsync(Vsync),
        .Href(Href), .Data(Data), .regWrite(rw2), .addr_in(addr2), .data_in(dat2),
        .Busy(busy2), .Done(done2), .Frame_err(err2));

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  e332;
        logic [11:0] e444;
        logic [15:0] e565;
    } vec_t;

    vec_t vecs[8];

    int total = 0;
    int bad   = 0;

    // Strobe/Done log written only by the monitor
    int wr_cnt = 0;
    int addr_log[256];
    int done_cnt = 0;
    int busy_drops = 0;
    logic last_err = 1'b0;
    logic watch = 1'b0;
    int done_goal = 0;

    always @(negedge clk) begin
        if (rw0) begin
            if (wr_cnt < 256) addr_log[wr_cnt] = int'(addr0);
            wr_cnt++;
        end
        if (done0) begin
            done_cnt++;
            last_err = err0;
        end
        if (watch && !busy0 && done_cnt < done_goal) busy_drops++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d, input logic a);
        @(negedge clk);
        Vsync = vs;
        Href  = hr;
        Data  = d;
        Arm   = a;
    endtask

    task automatic pulse_arm();
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Full frame of F8/1F pixel pairs; arm_at >= 0 pulses Arm at that byte of line 0
    task automatic frame(input int nlines, input int bytes0, input int bytes_n, input int arm_at);
        repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            int n;
            n = (l == 0) ? bytes0 : bytes_n;
            for (int b = 0; b < n; b++)
                drive(1'b0, 1'b1, (b % 2 == 1) ? 8'h1F : 8'hF8, (l == 0 && b == arm_at));
            repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        end
        repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_regwrite"}, 32'(rw0), 32'd0);
        check({tag, "_addr"},     32'(addr0), 32'd0);
        check({tag, "_data"},     32'(dat0), 32'd0);
        check({tag, "_busy"},     32'(busy0), 32'd0);
        check({tag, "_done"},     32'(done0), 32'd0);
        check({tag, "_err"},      32'(err0), 32'd0);
    endtask

    initial begin
        int base, dbase;

        vecs[0] = '{8'hF8, 8'h1F, 8'hE3, 12'hF0F, 16'hF81F};
        vecs[1] = '{8'hAB, 8'hCD, 8'hAD, 12'hA76, 16'hABCD};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 12'h000, 16'h0000};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 12'hFFF, 16'hFFFF};
        vecs[4] = '{8'h12, 8'h34, 8'h0A, 12'h14A, 16'h1234};
        vecs[5] = '{8'h80, 8'h01, 8'h80, 12'h800, 16'h8001};
        vecs[6] = '{8'h07, 8'hE0, 8'h1C, 12'h0F0, 16'h07E0};
        vecs[7] = '{8'h55, 8'hAA, 8'h55, 12'h5B5, 16'h55AA};

        Rst = 1'b1; Arm = 1'b0; Continuous = 1'b0;
        Vsync = 1'b1; Href = 1'b0; Data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        Rst = 1'b0;

        // Table-driven frame: each pixel strobes one cycle after its second byte
        pulse_arm();
        check("arm_busy", 32'(busy0), 32'd1);
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        dbase = done_cnt;
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) begin
                int idx;
                idx = l * H + p;
                drive(1'b0, 1'b1, vecs[idx].b0, 1'b0);
                @(posedge clk); #1;
                check("strobe_low_b0", 32'(rw0), 32'd0);
                drive(1'b0, 1'b1, vecs[idx].b1, 1'b0);
                @(posedge clk); #1;
                check("strobe", 32'(rw0 & rw1 & rw2), 32'd1);
                check("addr", 32'(addr0), 32'(idx));
                check("rgb332", 32'(dat0), 32'(vecs[idx].e332));
                check("rgb444", 32'(dat1), 32'(vecs[idx].e444));
                check("rgb565", 32'(dat2), 32'(vecs[idx].e565));
            end
            repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("done_pulse", 32'(done0), 32'd1);
        check("done_err", 32'(err0), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done0), 32'd0);
        check("busy_fall", 32'(busy0), 32'd0);
        check("done_count_t1", 32'(done_cnt - dbase), 32'd1);

        // Over-long first line: extra pixels dropped, next line at addr 4, error flagged
        base = wr_cnt; dbase = done_cnt;
        pulse_arm();
        frame(2, 12, 8, -1);
        check("long_strobes", 32'(wr_cnt - base), 32'd8);
        check("long_addr3", 32'(addr_log[base + 3]), 32'd3);
        check("long_line1_addr", 32'(addr_log[base + 4]), 32'd4);
        check("long_done", 32'(done_cnt - dbase), 32'd1);
        check("long_err", 32'(last_err), 32'd1);
        check("long_err_sticky", 32'(err0), 32'd1);

        // Arm during an active frame: that frame skipped, next one captured
        base = wr_cnt; dbase = done_cnt;
        frame(2, 8, 8, 4);
        check("mid_arm_busy", 32'(busy0), 32'd1);
        check("mid_arm_err_clr", 32'(err0), 32'd0);
        check("mid_arm_skip", 32'(wr_cnt - base), 32'd0);
        frame(2, 8, 8, -1);
        check("mid_arm_next", 32'(wr_cnt - base), 32'd8);
        check("mid_arm_addr0", 32'(addr_log[base]), 32'd0);
        check("mid_arm_done", 32'(done_cnt - dbase), 32'd1);
        check("mid_arm_noerr", 32'(last_err), 32'd0);

        // Short frame (one line): geometry error
        dbase = done_cnt;
        pulse_arm();
        frame(1, 8, 8, -1);
        check("short_done", 32'(done_cnt - dbase), 32'd1);
        check("short_err", 32'(last_err), 32'd1);

        // Continuous capture over three frames
        base = wr_cnt; dbase = done_cnt;
        Continuous = 1'b1;
        pulse_arm();
        done_goal = dbase + 3;
        watch = 1'b1;
        frame(2, 8, 8, -1);
        check("cont_busy_between", 32'(busy0), 32'd1);
        pulse_arm();
        frame(2, 8, 8, -1);
        Continuous = 1'b0;
        frame(2, 8, 8, -1);
        watch = 1'b0;
        check("cont_strobes", 32'(wr_cnt - base), 32'd24);
        check("cont_done", 32'(done_cnt - dbase), 32'd3);
        check("cont_busy_drops", 32'(busy_drops), 32'd0);
        for (int f = 0; f < 3; f++) begin
            check("cont_first_addr", 32'(addr_log[base + 8 * f]), 32'd0);
            check("cont_last_addr", 32'(addr_log[base + 8 * f + 7]), 32'd7);
        end
        check("cont_idle", 32'(busy0), 32'd0);

        // Reset after three pixels written
        base = wr_cnt;
        pulse_arm();
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int b = 0; b < 6; b++)
            drive(1'b0, 1'b1, (b % 2 == 1) ? 8'h1F : 8'hF8, 1'b0);
        @(negedge clk);
        Rst = 1'b1;
        Data = 8'hF8;
        @(posedge clk); #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        Rst = 1'b0;
        for (int b = 0; b < 9; b++)
            drive(1'b0, 1'b1, (b % 2 == 1) ? 8'hF8 : 8'h1F, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_three_writes", 32'(wr_cnt - base), 32'd3);
        frame(2, 8, 8, -1);
        check("rst_no_arm_no_write", 32'(wr_cnt - base), 32'd3);
        pulse_arm();
        frame(2, 8, 8, -1);
        check("rst_rearm_writes", 32'(wr_cnt - base), 32'd11);
        check("rst_rearm_addr0", 32'(addr_log[base + 3]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
